// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute and drives the
// datapath mux, enable and memory-handshake controls.
// Optional build macro: MIPS_CTRL_ADDI_EN enables the add-immediate path
// (ADDIEX/ADDIWB). Without it, OP_ADDI decodes as an illegal instruction.
module mips_multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'd0,
    parameter logic [5:0] OP_J     = 6'd2,
    parameter logic [5:0] OP_BEQ   = 6'd4,
    parameter logic [5:0] OP_ADDI  = 6'd8,
    parameter logic [5:0] OP_LW    = 6'd35,
    parameter logic [5:0] OP_SW    = 6'd43
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11,
        ILLEGAL = 4'd12
    } state_t;

    state_t state_q, state_d;

    // funct is decoded by the ALU control, not here; OP_ADDI is only
    // consulted when the add-immediate path is built in.
    logic funct_unused;
    assign funct_unused = ^{funct, OP_ADDI};

    // State register with synchronous reset to FETCH.
    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Next-state sequencing; memory states wait on mem_ready.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (OpCode == OP_LW || OpCode == OP_SW) state_d = MEMADR;
                else if (OpCode == OP_RTYPE)            state_d = EXEC;
                else if (OpCode == OP_BEQ)              state_d = BRANCH;
                else if (OpCode == OP_J)                state_d = JUMP;
`ifdef MIPS_CTRL_ADDI_EN
                else if (OpCode == OP_ADDI)             state_d = ADDIEX;
`endif
                else                                    state_d = ILLEGAL;
            end
            MEMADR: begin
                if (OpCode == OP_LW)      state_d = MEMRD;
                else if (OpCode == OP_SW) state_d = MEMWR;
                else                      state_d = ILLEGAL;
            end
            MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
            MEMWB:   state_d = FETCH;
            MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
            EXEC:    state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BRANCH:  state_d = FETCH;
            JUMP:    state_d = FETCH;
            ADDIEX:  state_d = ADDIWB;
            ADDIWB:  state_d = FETCH;
            ILLEGAL: state_d = ILLEGAL;
            default: state_d = FETCH;
        endcase
    end

    // Moore control decode (FETCH strobes gated by mem_ready); reset blanks all.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        illegal     = 1'b0;
        state       = state_q;
        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE:  ALUSrcB = 2'b11;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ADDIWB:  RegWrite = 1'b1;
            ILLEGAL: illegal  = 1'b1;
            default: ;
        endcase
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = '0;
            ALUOp       = '0;
            PCSource    = '0;
            illegal     = 1'b0;
            state       = '0;
        end
    end

endmodule
